// File: rtl/game_ctrl_if.sv
// Move request handshake between a player-input requester and the game controller.
// The requester holds move_valid until it sees move_ack or move_err.
interface game_ctrl_if;
    logic       move_valid;
    logic       move_player;
    logic [3:0] move_pos;
    logic       move_ack;
    logic       move_err;

    modport master (
        output move_valid, move_player, move_pos,
        input  move_ack, move_err
    );

    modport slave (
        input  move_valid, move_player, move_pos,
        output move_ack, move_err
    );
endinterface

// File: rtl/game_ctrl.sv
// Tic-tac-toe referee: validates moves, keeps the board, detects win/draw, forfeits idle turns.
//  state   | meaning
//  S_TURN  | waiting for the current player's move; turn timer running
//  S_CHECK | one cycle evaluating the board of the player who just moved
//  S_OVER  | game decided; board and result frozen until new_game
module game_ctrl #(
    parameter int FIRST_PLAYER   = 0,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        new_game,
    game_ctrl_if.slave  mv,
    output logic [8:0]  purp,
    output logic [8:0]  gold,
    output logic        turn,
    output logic        timeout,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic [8:0]  win_line
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic FP = 1'(FIRST_PLAYER);

    // Ordered so that the lowest index wins when several lines complete at once.
    localparam logic [8:0] LINES [8] = '{9'h007, 9'h038, 9'h1C0, 9'h049,
                                         9'h092, 9'h124, 9'h111, 9'h054};

    typedef enum logic [1:0] {S_TURN, S_CHECK, S_OVER} state_t;

    state_t        state, state_nxt;
    logic [8:0]    purp_nxt, gold_nxt, win_line_nxt;
    logic [1:0]    winner_nxt;
    logic          turn_nxt, ack_q, ack_nxt, err_q, err_nxt, to_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic [TW-1:0] timer, timer_nxt;

    logic [8:0]    mover_brd, pos_mask, hit_mask;
    logic          hit, legal, expired;

    assign mv.move_ack = ack_q;
    assign mv.move_err = err_q;
    assign game_over   = (state == S_OVER);

    assign mover_brd = turn ? gold : purp;
    assign pos_mask  = 9'd1 << mv.move_pos;
    assign expired   = (timer == T_LAST);
    // A request is not re-judged while its previous rejection is still on the bus.
    assign legal     = mv.move_valid && !err_q && (mv.move_player == turn) &&
                       (mv.move_pos <= 4'd8) && (((purp | gold) & pos_mask) == 9'd0);

    always_comb begin
        hit      = 1'b0;
        hit_mask = '0;
        for (int i = 7; i >= 0; i--) begin
            if ((mover_brd & LINES[i]) == LINES[i]) begin
                hit      = 1'b1;
                hit_mask = LINES[i];
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        purp_nxt     = purp;
        gold_nxt     = gold;
        turn_nxt     = turn;
        cnt_nxt      = cnt;
        winner_nxt   = winner;
        win_line_nxt = win_line;
        timer_nxt    = '0;
        ack_nxt      = 1'b0;
        err_nxt      = 1'b0;
        to_nxt       = 1'b0;
        if (new_game) begin
            state_nxt    = S_TURN;
            purp_nxt     = '0;
            gold_nxt     = '0;
            turn_nxt     = FP;
            cnt_nxt      = '0;
            winner_nxt   = '0;
            win_line_nxt = '0;
        end else begin
            case (state)
                S_TURN: begin
                    if (legal) begin
                        if (turn) gold_nxt = gold | pos_mask;
                        else      purp_nxt = purp | pos_mask;
                        cnt_nxt   = cnt + 4'd1;
                        ack_nxt   = 1'b1;
                        state_nxt = S_CHECK;
                    end else if (expired) begin
                        turn_nxt = ~turn;
                        to_nxt   = 1'b1;
                    end else begin
                        timer_nxt = timer + TW'(1);
                        err_nxt   = mv.move_valid && !err_q;
                    end
                end
                S_CHECK: begin
                    if (hit) begin
                        winner_nxt   = turn ? 2'b10 : 2'b01;
                        win_line_nxt = hit_mask;
                        state_nxt    = S_OVER;
                    end else if (cnt == 4'd9) begin
                        winner_nxt   = 2'b11;
                        win_line_nxt = '0;
                        state_nxt    = S_OVER;
                    end else begin
                        turn_nxt  = ~turn;
                        state_nxt = S_TURN;
                    end
                end
                S_OVER:  state_nxt = S_OVER;
                default: state_nxt = S_TURN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_TURN;
            purp     <= '0;
            gold     <= '0;
            turn     <= FP;
            cnt      <= '0;
            timer    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            timeout  <= 1'b0;
            winner   <= '0;
            win_line <= '0;
        end else begin
            state    <= state_nxt;
            purp     <= purp_nxt;
            gold     <= gold_nxt;
            turn     <= turn_nxt;
            cnt      <= cnt_nxt;
            timer    <= timer_nxt;
            ack_q    <= ack_nxt;
            err_q    <= err_nxt;
            timeout  <= to_nxt;
            winner   <= winner_nxt;
            win_line <= win_line_nxt;
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: a board-level game model is compared every cycle,
// plus literal expectations for the classic scenarios.
module tb_game_ctrl;
    localparam int TO = 8;

    logic       clk = 1'b0, reset_n = 1'b0, new_game = 1'b0;
    logic [8:0] purp, gold, win_line;
    logic [1:0] winner;
    logic       turn, timeout, game_over;

    game_ctrl_if mv_if();

    game_ctrl #(.FIRST_PLAYER(0), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .new_game(new_game), .mv(mv_if),
        .purp(purp), .gold(gold), .turn(turn), .timeout(timeout),
        .game_over(game_over), .winner(winner), .win_line(win_line)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int n_ack = 0, n_err = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---- game model: board as cell owners (0 empty, 1 purple, 2 gold) ----
    int         brd [9];
    int         lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                                 '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    int         m_turn, moves, idle, p;
    bit         m_check, m_over, m_ack, m_err, m_to, prev_err, want, found;
    logic [1:0] m_win;
    logic [8:0] m_line;

    task automatic model_clear();
        for (int i = 0; i < 9; i++) brd[i] = 0;
        m_turn = 0; moves = 0; idle = 0;
        m_check = 0; m_over = 0; m_ack = 0; m_err = 0; m_to = 0;
        m_win = 2'b00; m_line = '0;
    endtask

    function automatic logic [8:0] exp_board(int who);
        logic [8:0] r = '0;
        for (int i = 0; i < 9; i++) if (brd[i] == who) r[i] = 1'b1;
        return r;
    endfunction

    task automatic model_step();
        prev_err = m_err;
        m_ack = 0; m_err = 0; m_to = 0;
        if (new_game) begin
            model_clear();
        end else if (m_over) begin
            m_ack = 0;
        end else if (m_check) begin
            found = 0;
            for (int i = 0; i < 8; i++)
                if (!found && brd[lines[i][0]] == m_turn + 1 && brd[lines[i][1]] == m_turn + 1
                    && brd[lines[i][2]] == m_turn + 1) begin
                    found  = 1;
                    m_win  = (m_turn == 0) ? 2'b01 : 2'b10;
                    m_line = 9'((1 << lines[i][0]) | (1 << lines[i][1]) | (1 << lines[i][2]));
                end
            if (found) m_over = 1;
            else if (moves == 9) begin m_win = 2'b11; m_line = '0; m_over = 1; end
            else begin m_turn = 1 - m_turn; idle = 0; end
            m_check = 0;
        end else begin
            p    = int'(mv_if.move_pos);
            want = mv_if.move_valid && !prev_err;
            if (want && int'(mv_if.move_player) == m_turn && p <= 8 && brd[p] == 0) begin
                brd[p] = m_turn + 1; moves++; m_ack = 1; m_check = 1; idle = 0;
            end else if (idle == TO - 1) begin
                m_to = 1; m_turn = 1 - m_turn; idle = 0;
            end else begin
                if (want) m_err = 1;
                idle++;
            end
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_clear();
            else model_step();
        end
    end

    // every-cycle comparison against the model, plus pulse counters
    initial forever begin
        @(negedge clk);
        chk("purp",     32'(purp),          32'(exp_board(1)));
        chk("gold",     32'(gold),          32'(exp_board(2)));
        chk("turn",     32'(turn),          32'(m_turn));
        chk("ack",      32'(mv_if.move_ack), 32'(m_ack));
        chk("err",      32'(mv_if.move_err), 32'(m_err));
        chk("timeout",  32'(timeout),       32'(m_to));
        chk("game_over", 32'(game_over),    32'(m_over));
        chk("winner",   32'(winner),        32'(m_win));
        chk("win_line", 32'(win_line),      32'(m_line));
        if (mv_if.move_ack) n_ack++;
        if (mv_if.move_err) n_err++;
    end

    // ---- stimulus helpers (inputs change on the falling edge) ----
    task automatic req(bit pl, int pos);
        @(negedge clk);
        mv_if.move_valid = 1'b1; mv_if.move_player = pl; mv_if.move_pos = 4'(pos);
        @(negedge clk);
        mv_if.move_valid = 1'b0;
    endtask

    task automatic move(bit pl, int pos);
        req(pl, pos);
        @(negedge clk);
    endtask

    task automatic start_new();
        @(negedge clk); new_game = 1'b1;
        @(negedge clk); new_game = 1'b0;
    endtask

    task automatic play(int seq[], int len);
        for (int i = 0; i < len; i++) move(bit'(i % 2), seq[i]);
    endtask

    int a0, e0, k;
    int win_seq[]  = '{4, 0, 2, 1, 6};
    int draw_seq[] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

    initial begin
        mv_if.move_valid = 1'b0; mv_if.move_player = 1'b0; mv_if.move_pos = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_purp", 32'(purp), 32'h0);
        chk("rst_turn", 32'(turn), 32'h0);
        chk("rst_winner", 32'(winner), 32'h0);
        reset_n = 1'b1;

        // purple wins on the anti-diagonal
        a0 = n_ack;
        play(win_seq, 5);
        #1;
        chk("win_acks", 32'(n_ack - a0), 32'd5);
        chk("win_winner", 32'(winner), 32'h1);
        chk("win_line", 32'(win_line), 32'h054);
        chk("win_over", 32'(game_over), 32'h1);
        e0 = n_err;
        req(1'b1, 5);
        @(negedge clk); #1;
        chk("over_ignore_err", 32'(n_err - e0), 32'd0);
        chk("over_gold", 32'(gold), 32'h003);

        // same player twice
        start_new();
        e0 = n_err;
        move(1'b0, 0);
        req(1'b0, 1); #1;
        chk("dup_err", 32'(n_err - e0), 32'd1);
        chk("dup_purp", 32'(purp), 32'h001);
        chk("dup_turn", 32'(turn), 32'h1);
        req(1'b1, 9);
        req(1'b1, 0); #1;
        chk("bad_errs", 32'(n_err - e0), 32'd3);
        chk("bad_board", 32'({gold, purp}), 32'({9'h000, 9'h001}));

        // held-high wrong-player request re-pulses every other cycle
        start_new();
        e0 = n_err;
        @(negedge clk);
        mv_if.move_valid = 1'b1; mv_if.move_player = 1'b1; mv_if.move_pos = 4'd3;
        repeat (4) @(negedge clk);
        mv_if.move_valid = 1'b0; #1;
        chk("held_errs", 32'(n_err - e0), 32'd2);

        // draw
        start_new();
        play(draw_seq, 9);
        #1;
        chk("draw_winner", 32'(winner), 32'h3);
        chk("draw_full", 32'(purp | gold), 32'h1FF);
        chk("draw_line", 32'(win_line), 32'h0);

        // idle turn forfeit
        start_new();
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (timeout) begin k = i; break; end
        end
        chk("to_delay", 32'(k), 32'd8);
        chk("to_turn", 32'(turn), 32'h1);
        chk("to_board", 32'(purp | gold), 32'h0);

        // legal move landing on the expiry cycle wins over the forfeit
        repeat (7) @(negedge clk);
        mv_if.move_valid = 1'b1; mv_if.move_player = 1'b1; mv_if.move_pos = 4'd4;
        @(negedge clk);
        chk("exp_ack", 32'(mv_if.move_ack), 32'h1);
        chk("exp_no_to", 32'(timeout), 32'h0);
        mv_if.move_valid = 1'b0;
        @(negedge clk);
        chk("exp_gold", 32'(gold), 32'h010);
        chk("exp_turn", 32'(turn), 32'h0);

        // new_game beats a pending move in OVER
        start_new();
        play(win_seq, 5);
        @(negedge clk);
        new_game = 1'b1;
        mv_if.move_valid = 1'b1; mv_if.move_player = 1'b0; mv_if.move_pos = 4'd4;
        @(negedge clk);
        new_game = 1'b0; mv_if.move_valid = 1'b0;
        chk("ng_ack", 32'(mv_if.move_ack), 32'h0);
        chk("ng_board", 32'(purp | gold), 32'h0);
        chk("ng_turn", 32'(turn), 32'h0);
        chk("ng_over", 32'(game_over), 32'h0);

        // reset during CHECK discards the move immediately
        @(negedge clk);
        mv_if.move_valid = 1'b1; mv_if.move_player = 1'b0; mv_if.move_pos = 4'd0;
        @(negedge clk);
        mv_if.move_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("rc_board", 32'(purp | gold), 32'h0);
        chk("rc_ack", 32'(mv_if.move_ack), 32'h0);
        chk("rc_winner", 32'({winner, win_line}), 32'h0);
        chk("rc_over", 32'(game_over), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        move(1'b0, 3);
        chk("rc_resume", 32'(purp), 32'h008);
        chk("rc_turn", 32'(turn), 32'h1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
